// File: rtl/router_pkt_ctrl.sv
// Ingress controller for the 1x3 packet router: decodes the header byte,
// steers header/payload/parity into one of three FIFOs, checks length and
// parity, and flushes any output port that is left undrained too long.

// Per-port drain watchdog: pulses soft_reset after TIMEOUT consecutive stalled cycles.
module router_pkt_tmo #(
    parameter int TIMEOUT = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    output logic soft_reset
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tcnt;

    // Count stalled cycles; the TIMEOUT-th one fires the pulse and restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt       <= '0;
            soft_reset <= 1'b0;
        end else if (stall) begin
            if (tcnt == TW'(TIMEOUT - 1)) begin
                tcnt       <= '0;
                soft_reset <= 1'b1;
            end else begin
                tcnt       <= tcnt + TW'(1);
                soft_reset <= 1'b0;
            end
        end else begin
            tcnt       <= '0;
            soft_reset <= 1'b0;
        end
    end
endmodule

module router_pkt_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic       busy,
    output logic [2:0] write_enb,
    output logic [7:0] fifo_wdata,
    output logic       lfd,
    output logic       err,
    output logic [2:0] soft_reset
);
    localparam int NUM_PORTS = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD,
        CHECK,
        DROP
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] dest;
    logic [7:0] hdr;
    logic [7:0] parity;
    logic [7:0] rx_par;
    logic [5:0] cnt;

    // One-hot port selects; address 3 decodes to no port at all, which keeps
    // every per-port lookup in range.
    logic [2:0] hdr_sel, dest_sel;
    logic       hdr_empty, dest_empty, dest_full, dest_sr;
    logic [NUM_PORTS-1:0] stall;

    assign hdr_sel    = 3'b001 << data_in[1:0];
    assign dest_sel   = 3'b001 << dest;
    assign hdr_empty  = |(fifo_empty & hdr_sel);
    assign dest_empty = |(fifo_empty & dest_sel);
    assign dest_full  = |(fifo_full & dest_sel);
    assign dest_sr    = |(soft_reset & dest_sel);
    assign stall      = ~fifo_empty & ~read_enb;

    router_pkt_tmo #(.TIMEOUT(TIMEOUT)) u_tmo [NUM_PORTS-1:0] (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .soft_reset (soft_reset)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus the zero-latency write path and source back-pressure.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        write_enb  = '0;
        lfd        = 1'b0;
        fifo_wdata = data_in;
        case (state)
            IDLE: begin
                if (pkt_valid) begin
                    if (data_in[1:0] == 2'd3) begin
                        state_nxt = DROP;
                    end else if (hdr_empty) begin
                        write_enb = hdr_sel;
                        lfd       = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = WAIT_EMPTY;
                    end
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (dest_sr) begin
                    state_nxt = DROP;
                end else if (dest_empty) begin
                    // Source has already moved past the header; replay the latched copy.
                    write_enb  = dest_sel;
                    lfd        = 1'b1;
                    fifo_wdata = hdr;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                busy = dest_full;
                if (!dest_full) begin
                    if (dest_sr) begin
                        // Port was flushed under us: swallow this byte and the rest.
                        state_nxt = pkt_valid ? DROP : IDLE;
                    end else begin
                        write_enb = dest_sel;
                        if (!pkt_valid) state_nxt = CHECK;
                    end
                end else if (dest_sr) begin
                    state_nxt = DROP;
                end
            end
            CHECK: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            DROP: begin
                if (!pkt_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            write_enb = '0;
            lfd       = 1'b0;
        end
    end

    // Packet bookkeeping: header latch, running parity, byte count and error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            dest   <= '0;
            hdr    <= '0;
            parity <= '0;
            rx_par <= '0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pkt_valid) begin
                        // Parity seeds with the header on both the direct and the
                        // WAIT_EMPTY path; nothing else touches it until LOAD.
                        hdr    <= data_in;
                        parity <= data_in;
                        cnt    <= '0;
                        err    <= 1'b0;
                        if (data_in[1:0] != 2'd3) dest <= data_in[1:0];
                    end
                end
                LOAD: begin
                    if (!dest_full) begin
                        if (dest_sr) begin
                            if (!pkt_valid) err <= 1'b1;
                        end else if (pkt_valid) begin
                            parity <= parity ^ data_in;
                            if (cnt != 6'h3F) cnt <= cnt + 6'd1;
                        end else begin
                            rx_par <= data_in;
                        end
                    end
                end
                CHECK: err <= (parity != rx_par) || (cnt != hdr[7:2]);
                DROP: begin
                    if (!pkt_valid) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_router_pkt_ctrl.sv
module tb_router_pkt_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic       busy, lfd, err;
    logic [2:0] write_enb, soft_reset;
    logic [7:0] fifo_wdata;

    router_pkt_ctrl #(.TIMEOUT(30)) dut (
        .clock      (clock),
        .reset      (reset),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .busy       (busy),
        .write_enb  (write_enb),
        .fifo_wdata (fifo_wdata),
        .lfd        (lfd),
        .err        (err),
        .soft_reset (soft_reset)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       rst;
        logic       pv;
        logic [7:0] d;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] rd;
        logic       busy;
        logic [2:0] we;
        logic       lfd;
        logic       err;
        logic [2:0] sr;
        logic [7:0] wd;
    } vec_t;

    vec_t vec[$];
    int   tests = 0;
    int   failed = 0;

    logic [7:0] pl [0:15] = '{8'h3C, 8'hA5, 8'h11, 8'hF0, 8'h5A, 8'h07, 8'hC3, 8'h99,
                              8'h6E, 8'h42, 8'hB8, 8'h1D, 8'hE7, 8'h80, 8'h2B, 8'hD4};

    function automatic logic [7:0] xr(input logic [7:0] h, input int n);
        logic [7:0] p = h;
        for (int k = 0; k < n; k++) p = p ^ pl[k];
        return p;
    endfunction

    task automatic add(input logic rst, input logic pv, input logic [7:0] d,
                       input logic [2:0] full, input logic [2:0] empty, input logic [2:0] rd,
                       input logic b, input logic [2:0] we, input logic l, input logic e,
                       input logic [2:0] sr, input logic [7:0] wd);
        vec_t v;
        v = '{rst:rst, pv:pv, d:d, full:full, empty:empty, rd:rd,
              busy:b, we:we, lfd:l, err:e, sr:sr, wd:wd};
        vec.push_back(v);
    endtask

    task automatic nrm(input logic pv, input logic [7:0] d, input logic b,
                       input logic [2:0] we, input logic l, input logic e);
        add(1'b0, pv, d, 3'b000, 3'b111, 3'b111, b, we, l, e, 3'b000, d);
    endtask

    initial begin
        #200000;
        failed++;
        $display("FAIL timeout: bench did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        logic [7:0] par;

        add(1'b1, 1'b0, 8'h00, 3'b000, 3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 8'h00);

        nrm(1'b1, 8'h01, 1'b0, 3'b010, 1'b1, 1'b0);
        nrm(1'b0, 8'h01, 1'b0, 3'b010, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);

        nrm(1'b1, 8'h21, 1'b0, 3'b010, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) nrm(1'b1, pl[i], 1'b0, 3'b010, 1'b0, 1'b0);
        nrm(1'b0, xr(8'h21, 8), 1'b0, 3'b010, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);

        nrm(1'b1, 8'h10, 1'b0, 3'b001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) nrm(1'b1, pl[i], 1'b0, 3'b001, 1'b0, 1'b0);
        par = xr(8'h10, 4) ^ 8'h01;
        nrm(1'b0, par, 1'b0, 3'b001, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);

        nrm(1'b1, 8'h42, 1'b0, 3'b100, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) nrm(1'b1, pl[i], 1'b0, 3'b100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b1, pl[6], 3'b100, 3'b011, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, pl[6]);
        for (int i = 6; i < 16; i++) nrm(1'b1, pl[i], 1'b0, 3'b100, 1'b0, 1'b0);
        nrm(1'b0, xr(8'h42, 16), 1'b0, 3'b100, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);

        add(1'b0, 1'b1, 8'h06, 3'b000, 3'b011, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 8'h06);
        add(1'b0, 1'b1, pl[0], 3'b000, 3'b011, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, pl[0]);
        add(1'b0, 1'b1, pl[0], 3'b000, 3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 1'b0, 3'b000, 8'h06);
        nrm(1'b1, pl[0], 1'b0, 3'b100, 1'b0, 1'b0);
        par = xr(8'h06, 1);
        add(1'b0, 1'b0, par, 3'b100, 3'b111, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, par);
        nrm(1'b0, par, 1'b0, 3'b100, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);

        nrm(1'b1, 8'h17, 1'b0, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) nrm(1'b1, pl[i], 1'b0, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'hAA, 1'b0, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);

        nrm(1'b1, 8'h20, 1'b0, 3'b001, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) nrm(1'b1, pl[i], 1'b0, 3'b001, 1'b0, 1'b0);
        nrm(1'b0, xr(8'h20, 6), 1'b0, 3'b001, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);

        for (int c = 0; c < 30; c++)
            add(1'b0, 1'b0, 8'h00, 3'b000, 3'b110, 3'b110, 1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 8'h00);
        add(1'b0, 1'b0, 8'h00, 3'b000, 3'b110, 3'b110, 1'b0, 3'b000, 1'b0, 1'b1, 3'b001, 8'h00);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);

        for (int c = 0; c < 33; c++)
            add(1'b0, 1'b0, 8'h00, 3'b000, 3'b110, (c == 29) ? 3'b111 : 3'b110,
                1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 8'h00);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);

        nrm(1'b1, 8'h08, 1'b0, 3'b001, 1'b1, 1'b1);
        for (int c = 0; c < 30; c++)
            add(1'b0, 1'b1, pl[0], 3'b001, 3'b110, 3'b110, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, pl[0]);
        add(1'b0, 1'b1, pl[0], 3'b000, 3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 3'b001, pl[0]);
        nrm(1'b1, pl[1], 1'b0, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'h5A, 1'b0, 3'b000, 1'b0, 1'b0);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b1);

        nrm(1'b1, 8'h10, 1'b0, 3'b001, 1'b1, 1'b1);
        nrm(1'b1, pl[0], 1'b0, 3'b001, 1'b0, 1'b0);
        add(1'b1, 1'b1, pl[1], 3'b000, 3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, pl[1]);
        nrm(1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 1'b0);
        nrm(1'b1, 8'h09, 1'b0, 3'b010, 1'b1, 1'b0);

        reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
        fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b111;
        repeat (2) @(posedge clock);

        @(negedge clock);
        tests++;
        if ({busy, write_enb, lfd, err, soft_reset} !== 11'b0 || dut.state !== dut.IDLE) begin
            failed++;
            $display("FAIL reset state: busy/we/lfd/err/sr %b state %0d",
                     {busy, write_enb, lfd, err, soft_reset}, dut.state);
        end

        foreach (vec[i]) begin
            logic [10:0] got, exp;
            @(negedge clock);
            reset      = vec[i].rst;
            pkt_valid  = vec[i].pv;
            data_in    = vec[i].d;
            fifo_full  = vec[i].full;
            fifo_empty = vec[i].empty;
            read_enb   = vec[i].rd;
            #2;
            got = {busy, write_enb, lfd, err, soft_reset};
            exp = {vec[i].busy, vec[i].we, vec[i].lfd, vec[i].err, vec[i].sr};
            tests++;
            if (got !== exp || (vec[i].we != 3'b000 && fifo_wdata !== vec[i].wd)) begin
                failed++;
                $display("FAIL vec%0d busy/we/lfd/err/sr got %b wdata %h, expected %b wdata %h",
                         i, got, fifo_wdata, exp, vec[i].wd);
            end
        end

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
